data_memory_param: RTL and testbench
====================================

// Module: data_memory_param
// PURPOSE
//  Parametrised single-port data memory for the RISC core's MEM stage with a valid/ready request port,
//  byte-enabled writes, configurable read latency and a sequential clear engine (no bulk reset of the array).
//  Sits between the load/store unit and the writeback mux; replaces the fixed 64x16 data memory.
// PARAMETERS
//  DATA_W   16  word width in bits; must be a multiple of 8
//  DEPTH    64  number of words; need not be a power of two
//  ADDR_W   $clog2(DEPTH)  address width (derived, not overridable)
//  RD_LAT   1   read latency in cycles from accept to rsp_valid; legal values 1 or 2
//  INIT_VAL 0   value written to every word by the clear sweep
// PORTS
//  clk        in   1          clock, all state on rising edge
//  rst        in   1          asynchronous, active-high reset
//  clr        in   1          synchronous pulse: restart clear sweep
//  req_valid  in   1          request present
//  req_ready  out  1          request accepted when req_valid & req_ready
//  req_we     in   1          1 = write, 0 = read
//  req_addr   in   ADDR_W     word address
//  req_wdata  in   DATA_W     write data
//  req_be     in   DATA_W/8   byte enables, bit i covers wdata[8i+7:8i]
//  rsp_valid  out  1          one-cycle pulse per accepted read
//  rsp_rdata  out  DATA_W     read data; holds last value between responses
//  rsp_err    out  1          qualifies rsp_valid: address was >= DEPTH
//  wr_err     out  1          one-cycle pulse: accepted write had address >= DEPTH
//  init_done  out  1          1 when no clear sweep is in progress
// BEHAVIOUR
//  - Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0, init_done=0;
//    FSM -> SWEEP, sweep counter=0. Array contents are not reset directly.
//  - FSM states: SWEEP, IDLE. SWEEP writes INIT_VAL to word cnt each cycle, cnt increments;
//    at cnt==DEPTH-1 the write completes and FSM -> IDLE next cycle. Sweep takes exactly DEPTH cycles.
//  - init_done = (state==IDLE); req_ready = init_done & ~clr. Requests are never accepted during SWEEP.
//  - clr in IDLE or SWEEP: counter -> 0, state -> SWEEP next cycle; clr beats a same-cycle request
//    (request not accepted). rst mid-sweep restarts the sweep from word 0.
//  - Accepted write, addr<DEPTH: bytes with req_be[i]=1 updated at that clock edge; others unchanged;
//    req_be=0 is a legal no-op write. addr>=DEPTH: array untouched, wr_err=1 next cycle.
//  - Accepted read: rsp_valid=1 exactly RD_LAT cycles later, one response per accept, in order.
//    addr>=DEPTH: rsp_rdata=0, rsp_err=1. Back-to-back reads sustain one per cycle.
//  - Read-after-write: a read accepted the cycle after a write to the same address returns new data.
//  - RD_LAT=2: data registered twice; second stage holds rsp_rdata when no response is due.
//  - In-flight read responses still complete after clr (data captured before sweep overwrites).
//  - rst asserted mid-read: pipeline cleared, no response emitted for that read.
//  - Single port: one access per cycle; the sweep owns the write port while in SWEEP.
// STRUCTURE
//  - Package data_mem_pkg: state enum {SWEEP, IDLE}, RD_LAT legal-value check, byte-enable width function.
//  - Sub-module data_mem_sweep: counter + FSM producing sweep_we, sweep_addr, init_done.
//  - Top: array, write-port mux (sweep vs request), byte-merge, RD_LAT response shift pipeline.
// TESTING
//  1. rst pulse, DEPTH=64: init_done=0 for 64 cycles, then 1; read all words -> 0x0000, rsp_err=0.
//  2. Write 0xBEEF @5 be=11, then write 0x1200 @5 be=10, read @5 -> 0x12EF after RD_LAT (1 and 2).
//  3. Write 0xA5A5 @63 then read @63 next cycle -> 0xA5A5; DEPTH=48 read @50 -> rdata 0, rsp_err=1;
//     write @50 -> wr_err pulse, word 50 mod 48 unchanged.
//  4. Back-to-back reads @1,@2,@3 with distinct data -> three consecutive rsp_valid cycles, in order.
//  5. Read @7 (=0x7777) accepted, clr next cycle -> response 0x7777 still delivered; req_ready=0
//     for DEPTH+1 cycles; then read @7 -> INIT_VAL.
//  6. rst asserted at sweep count 20 -> sweep restarts, init_done rises DEPTH cycles after rst release.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and elaboration helpers for the parametrised MEM-stage data memory.
package data_mem_pkg;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic bit rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/data_mem_sweep.sv
// Clear engine: walks every word once after reset or clr, then reports init_done.
module data_mem_sweep
  import data_mem_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SWEEP;
      cnt   <= '0;
    end else if (clr) begin
      state <= SWEEP;
      cnt   <= '0;
    end else begin
      case (state)
        SWEEP: begin
          if (cnt == LAST) state <= IDLE;
          else             cnt   <= cnt + 1'b1;
        end
        IDLE:    state <= IDLE;
        default: state <= SWEEP;
      endcase
    end
  end

  assign sweep_we   = (state == SWEEP);
  assign sweep_addr = cnt;
  assign init_done  = (state == IDLE);

endmodule

// File: rtl/data_memory_param.sv
// Single-port MEM-stage data memory: valid/ready requests, byte-enabled writes,
// 1- or 2-cycle read pipeline and a sequential clear sweep instead of an array reset.
module data_memory_param
  import data_mem_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 64,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  localparam int               ADDR_W   = $clog2(DEPTH),
  localparam int               BE_W     = be_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              wr_err,
  output logic              init_done
);

  if (!rd_lat_legal(RD_LAT) || (DATA_W % 8 != 0)) begin : g_bad_param
    $error("data_memory_param: RD_LAT must be 1 or 2 and DATA_W a multiple of 8");
  end

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              addr_ok;
  logic              wr_fire;
  logic              rd_fire;

  data_mem_sweep #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr),
    .init_done  (init_done)
  );

  // clr wins over a same-cycle request; nothing is accepted while sweeping.
  assign req_ready = init_done & ~clr;
  assign wr_fire   = req_valid & req_ready &  req_we;
  assign rd_fire   = req_valid & req_ready & ~req_we;

  if (DEPTH == (1 << ADDR_W)) begin : g_pow2
    assign addr_ok = 1'b1;
  end else begin : g_npow2
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
    assign addr_ok = (req_addr < LIMIT);
  end

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; the sweep clears it so it can map onto a plain RAM.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_addr] <= INIT_VAL;
    end else if (wr_fire && addr_ok) begin
      for (int i = 0; i < BE_W; i++) begin
        if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= wr_fire & ~addr_ok;
  end

  // First read stage: data captured at accept, so a later clr sweep cannot corrupt it.
  logic              p1_valid;
  logic              p1_err;
  logic [DATA_W-1:0] p1_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid <= 1'b0;
      p1_err   <= 1'b0;
      p1_data  <= '0;
    end else begin
      p1_valid <= rd_fire;
      p1_err   <= rd_fire & ~addr_ok;
      if (rd_fire) p1_data <= addr_ok ? mem[req_addr] : '0;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              p2_valid;
    logic              p2_err;
    logic [DATA_W-1:0] p2_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        p2_valid <= 1'b0;
        p2_err   <= 1'b0;
        p2_data  <= '0;
      end else begin
        p2_valid <= p1_valid;
        p2_err   <= p1_err;
        if (p1_valid) p2_data <= p1_data;
      end
    end

    assign rsp_valid = p2_valid;
    assign rsp_err   = p2_err;
    assign rsp_rdata = p2_data;
  end else begin : g_lat1
    assign rsp_valid = p1_valid;
    assign rsp_err   = p1_err;
    assign rsp_rdata = p1_data;
  end

endmodule

// File: tb/tb_data_memory_param.sv
// Scoreboard bench: two configurations (64 words/RD_LAT 1, 48 words/RD_LAT 2) share one stimulus stream.
module tb_data_memory_param;

  localparam logic [15:0] INIT_B = 16'h5A5A;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [5:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;

  logic        req_ready_a, rsp_valid_a, rsp_err_a, wr_err_a, init_done_a;
  logic [15:0] rsp_rdata_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, wr_err_b, init_done_b;
  logic [15:0] rsp_rdata_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] mem_a [64];
  logic [15:0] mem_b [48];
  rsp_t        q_a[$];
  rsp_t        q_b[$];
  int          wq_a[$];
  int          wq_b[$];

  data_memory_param #(.DATA_W(16), .DEPTH(64), .RD_LAT(1), .INIT_VAL(16'h0000)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .wr_err(wr_err_a), .init_done(init_done_a)
  );

  data_memory_param #(.DATA_W(16), .DEPTH(48), .RD_LAT(2), .INIT_VAL(INIT_B)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .wr_err(wr_err_b), .init_done(init_done_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] wd,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = wd[7:0];
    if (be[1]) r[15:8] = wd[15:8];
    return r;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mem_a[i] = 16'h0000;
    for (int i = 0; i < 48; i++) mem_b[i] = INIT_B;
  endtask

  // Drive one request for one cycle; the model assumes it is accepted at the next edge.
  task automatic issue(input bit we, input logic [5:0] addr, input logic [15:0] wd,
                       input logic [1:0] be, input bit track);
    int a;
    rsp_t e;
    a = int'(addr);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    if (we) begin
      if (a < 64) mem_a[a] = merge(mem_a[a], wd, be); else wq_a.push_back(cyc + 1);
      if (a < 48) mem_b[a] = merge(mem_b[a], wd, be); else wq_b.push_back(cyc + 1);
    end else if (track) begin
      e.data = (a < 64) ? mem_a[a] : 16'h0000; e.err = (a >= 64); e.due = cyc + 1;
      q_a.push_back(e);
      e.data = (a < 48) ? mem_b[a] : 16'h0000; e.err = (a >= 48); e.due = cyc + 2;
      q_b.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0; req_we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready_a", req_ready_a, 0); check("rst_req_ready_b", req_ready_b, 0);
    check("rst_rsp_valid_a", rsp_valid_a, 0); check("rst_rsp_valid_b", rsp_valid_b, 0);
    check("rst_rdata_a", rsp_rdata_a, 0);     check("rst_rdata_b", rsp_rdata_b, 0);
    check("rst_rsp_err_a", rsp_err_a, 0);     check("rst_rsp_err_b", rsp_err_b, 0);
    check("rst_wr_err_a", wr_err_a, 0);       check("rst_wr_err_b", wr_err_b, 0);
    check("rst_init_done_a", init_done_a, 0); check("rst_init_done_b", init_done_b, 0);
    rst = 1'b0;
    model_clear();
  endtask

  // Counts edges from reset release until init_done is seen high.
  task automatic wait_init(input string tag);
    int na, nb;
    na = -1; nb = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (na < 0 && init_done_a) na = k;
      if (nb < 0 && init_done_b) nb = k;
      if (na >= 0 && nb >= 0) break;
    end
    check({tag, "_sweep_cycles_a"}, na, 64);
    check({tag, "_sweep_cycles_b"}, nb, 48);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin : mon_a
    rsp_t e;
    bit   exp_w;
    if (rsp_valid_a) begin
      if (q_a.size() == 0) check("a_spurious_rsp", rsp_valid_a, 0);
      else begin
        e = q_a.pop_front();
        check("a_rdata", rsp_rdata_a, e.data);
        check("a_rsp_err", rsp_err_a, e.err);
        check("a_rsp_cycle", cyc, e.due);
      end
    end
    exp_w = (wq_a.size() > 0) && (wq_a[0] == cyc);
    if (exp_w) void'(wq_a.pop_front());
    if (exp_w || wr_err_a) check("a_wr_err", wr_err_a, exp_w);
  end

  always @(negedge clk) begin : mon_b
    rsp_t e;
    bit   exp_w;
    if (rsp_valid_b) begin
      if (q_b.size() == 0) check("b_spurious_rsp", rsp_valid_b, 0);
      else begin
        e = q_b.pop_front();
        check("b_rdata", rsp_rdata_b, e.data);
        check("b_rsp_err", rsp_err_b, e.err);
        check("b_rsp_cycle", cyc, e.due);
      end
    end
    exp_w = (wq_b.size() > 0) && (wq_b[0] == cyc);
    if (exp_w) void'(wq_b.pop_front());
    if (exp_w || wr_err_b) check("b_wr_err", wr_err_b, exp_w);
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ca, cb;
    @(posedge clk); #1;
    do_reset();
    wait_init("por");

    // Whole array after power-up sweep, back-to-back.
    for (int i = 0; i < 64; i++) issue(1'b0, 6'(i), 16'h0, 2'b00, 1'b1);
    idle(3);

    // Byte-enable merge.
    issue(1'b1, 6'd5, 16'hBEEF, 2'b11, 1'b1);
    issue(1'b1, 6'd5, 16'h1200, 2'b10, 1'b1);
    issue(1'b0, 6'd5, 16'h0, 2'b00, 1'b1);
    idle(3);

    // Top word, read-after-write, out-of-range on the 48-word instance.
    issue(1'b1, 6'd63, 16'hA5A5, 2'b11, 1'b1);
    issue(1'b0, 6'd63, 16'h0, 2'b00, 1'b1);
    issue(1'b0, 6'd50, 16'h0, 2'b00, 1'b1);
    issue(1'b1, 6'd50, 16'hDEAD, 2'b11, 1'b1);
    issue(1'b0, 6'd2, 16'h0, 2'b00, 1'b1);
    issue(1'b0, 6'd50, 16'h0, 2'b00, 1'b1);
    idle(3);

    // Distinct data, consecutive reads, and a be=0 no-op write.
    issue(1'b1, 6'd1, 16'h1111, 2'b11, 1'b1);
    issue(1'b1, 6'd2, 16'h2222, 2'b11, 1'b1);
    issue(1'b1, 6'd3, 16'h3333, 2'b11, 1'b1);
    issue(1'b1, 6'd3, 16'hFFFF, 2'b00, 1'b1);
    issue(1'b0, 6'd1, 16'h0, 2'b00, 1'b1);
    issue(1'b0, 6'd2, 16'h0, 2'b00, 1'b1);
    issue(1'b0, 6'd3, 16'h0, 2'b00, 1'b1);
    idle(3);

    // In-flight read survives clr; a request alongside clr is refused.
    issue(1'b1, 6'd7, 16'h7777, 2'b11, 1'b1);
    issue(1'b0, 6'd7, 16'h0, 2'b00, 1'b1);
    clr = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd9;
    ca = 0; cb = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("clr_blocks_req_a", req_ready_a, 0);
        check("clr_blocks_req_b", req_ready_b, 0);
      end
      if (!req_ready_a) ca++;
      if (!req_ready_b) cb++;
      if (req_ready_a && req_ready_b) break;
      @(posedge clk); #1;
      clr = 1'b0; req_valid = 1'b0;
    end
    check("clr_not_ready_cycles_a", ca, 65);
    check("clr_not_ready_cycles_b", cb, 49);
    @(posedge clk); #1;
    model_clear();
    issue(1'b0, 6'd7, 16'h0, 2'b00, 1'b1);
    issue(1'b0, 6'd63, 16'h0, 2'b00, 1'b1);
    idle(3);

    // Reset while a read is in flight: no response may appear.
    issue(1'b1, 6'd10, 16'h3C3C, 2'b11, 1'b1);
    issue(1'b0, 6'd10, 16'h0, 2'b00, 1'b0);
    do_reset();

    // Reset again partway through the sweep; it must restart from word 0.
    repeat (20) @(posedge clk);
    #1;
    do_reset();
    wait_init("mid_sweep_rst");
    issue(1'b0, 6'd10, 16'h0, 2'b00, 1'b1);
    issue(1'b0, 6'd5, 16'h0, 2'b00, 1'b1);
    issue(1'b0, 6'd0, 16'h0, 2'b00, 1'b1);
    issue(1'b0, 6'd47, 16'h0, 2'b00, 1'b1);
    idle(6);

    check("pending_rsp_a", q_a.size(), 0);
    check("pending_rsp_b", q_b.size(), 0);
    check("pending_wr_err_a", wq_a.size(), 0);
    check("pending_wr_err_b", wq_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
